choice_table_sched: RTL and testbench
=====================================

Name: choice_table_sched

Overview:
- Sequences and shares a single-port 2-bit tournament chooser table (2^ADDR_W saturating counters) between two requesters.
- The fetch-stage lookup port reads a counter to pick predictor 1 or 2.
- The execute-stage update port applies resolved-branch outcomes via read-modify-write, buffered in a small FIFO.
- Also runs the post-reset table-clear walk; sits between the branch-prediction front end and the table RAM.

Parameters:
- ADDR_W, 12, table index width (table holds 2^ADDR_W entries).
- DEPTH, 4, update FIFO entries (power of 2, >=2).
- INIT_VAL, 2'b00, counter value written to every entry during init.

Ports:
- clk  in  1  clock; everything on rising edge.
- rst  in  1  synchronous, active-high reset.
- lookup_valid  in  1  lookup request.
- lookup_addr  in  ADDR_W  lookup index.
- lookup_ready  out  1  lookup accepted this cycle when valid&ready.
- lookup_resp_valid  out  1  choice valid (one cycle after acceptance).
- lookup_choice  out  1  1 = use predictor 2 (counter >= 2), 0 = predictor 1.
- upd_valid  in  1  resolved-branch update request.
- upd_addr  in  ADDR_W  update index.
- upd_taken1  in  1  predictor 1 was correct.
- upd_taken2  in  1  predictor 2 was correct.
- upd_ready  out  1  FIFO can accept an update.
- init_done  out  1  table clear finished.
- tbl_en  out  1  table access strobe.
- tbl_we  out  1  write (1) / read (0).
- tbl_addr  out  ADDR_W  table address.
- tbl_wdata  out  2  write data.
- tbl_rdata  in  2  read data, valid the cycle after a read strobe.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: FSM=INIT, init pointer=0, FIFO empty, lookup_ready=0, upd_ready=0, lookup_resp_valid=0, init_done=0, tbl_en=0.
- rst asserted at any time, including mid-RMW or mid-init, returns to INIT and flushes the FIFO; a pending read response is discarded.
- FSM states: INIT, IDLE, UPD_RD, UPD_WR.
- INIT:
  - Each cycle: tbl_en=1, tbl_we=1, tbl_addr=pointer, tbl_wdata=INIT_VAL, then pointer++.
  - After writing address 2^ADDR_W-1, go to IDLE; init_done=1 from the next cycle until reset.
  - lookup_ready=0 and upd_ready=0 throughout INIT.
- IDLE:
  - lookup_ready=1.
  - If lookup_valid: tbl_en=1, tbl_we=0, tbl_addr=lookup_addr; stay IDLE.
  - Else if FIFO non-empty: issue a read of the head entry address, pop the head into an RMW register, go to UPD_RD.
  - Lookups have strict priority for starting an access; updates may starve while lookups are continuous.
- UPD_RD (data returning):
  - lookup_ready=0, no table access; go to UPD_WR.
- UPD_WR:
  - lookup_ready=0.
  - Write new = f(tbl_rdata captured) to the RMW address; go to IDLE.
  - The write is always issued, even when the value is unchanged.
- Counter function f:
  - taken1=0, taken2=1: increment, saturating at 3.
  - taken1=1, taken2=0: decrement, saturating at 0.
  - Otherwise: unchanged.
- Lookup response: lookup_resp_valid=1 exactly one cycle after acceptance; lookup_choice=tbl_rdata[1] in that cycle; lookup_choice is don't-care otherwise.
- Lookup latency: 1 cycle.
- Update latency: best case 3 cycles from FIFO entry to write.
- FIFO:
  - upd_ready = !INIT && count<DEPTH, using the registered count.
  - Push and pop in the same cycle leave count unchanged.
  - Push when full is not possible (ready=0).
- Ordering:
  - Updates are applied in arrival order, with no forwarding between FIFO entries.
  - Back-to-back updates to the same address are correct because the write completes before the next RMW read.
  - Lookups may observe values not yet including queued updates; this is allowed.

Test Plan:
- Reset, then wait: tbl_we=1 for addresses 0..4095 over 4096 consecutive cycles with wdata=00; init_done rises the cycle after address 4095; ready=0 during the walk.
- After init, update addr 0x010 with taken1=0, taken2=1 three times, then lookup 0x010: writes seen are 01, 10, 11; lookup_choice=1 one cycle after acceptance.
- Counter at 11, update taken1=1, taken2=0 four times: writes 10, 01, 00, 00 (saturates); subsequent lookup returns 0; updates with taken1=taken2 write the value unchanged.
- Hold lookup_valid high for 20 cycles while pushing 5 updates: upd_ready drops after 4 entries (DEPTH=4) with no table writes; after lookup_valid drops, the 4 RMWs complete in FIFO order, one every 3 cycles.
- Assert rst during UPD_WR and during INIT at pointer 0x200: FSM restarts INIT at address 0, FIFO empty, no write from the aborted RMW, lookup_resp_valid=0.
- Lookup arriving in UPD_RD: lookup_ready=0 for 2 cycles, then accepted in IDLE with response the next cycle.

Source files
------------

// File: rtl/choice_table_sched_if.sv
// -----------------------------------------------------------------------------
// choice_table_sched_if
// Bundles the three buses around the tournament chooser-table scheduler:
//   - fetch-stage lookup port  : lookup_valid/addr in, lookup_ready,
//                                lookup_resp_valid, lookup_choice out
//   - execute-stage update port: upd_valid/addr/taken1/taken2 in, upd_ready out
//   - table RAM port           : tbl_en/we/addr/wdata out, tbl_rdata in
//   - status                   : init_done out
// Modport slave is the scheduler's view; modport master is the view of the
// surrounding logic (requesters plus the RAM).
// -----------------------------------------------------------------------------
interface choice_table_sched_if #(
    parameter int ADDR_W = 12
);
    logic              lookup_valid;
    logic [ADDR_W-1:0] lookup_addr;
    logic              lookup_ready;
    logic              lookup_resp_valid;
    logic              lookup_choice;

    logic              upd_valid;
    logic [ADDR_W-1:0] upd_addr;
    logic              upd_taken1;
    logic              upd_taken2;
    logic              upd_ready;

    logic              init_done;

    logic              tbl_en;
    logic              tbl_we;
    logic [ADDR_W-1:0] tbl_addr;
    logic [1:0]        tbl_wdata;
    logic [1:0]        tbl_rdata;

    modport slave (
        input  lookup_valid, lookup_addr,
        input  upd_valid, upd_addr, upd_taken1, upd_taken2,
        input  tbl_rdata,
        output lookup_ready, lookup_resp_valid, lookup_choice,
        output upd_ready, init_done,
        output tbl_en, tbl_we, tbl_addr, tbl_wdata
    );

    modport master (
        output lookup_valid, lookup_addr,
        output upd_valid, upd_addr, upd_taken1, upd_taken2,
        output tbl_rdata,
        input  lookup_ready, lookup_resp_valid, lookup_choice,
        input  upd_ready, init_done,
        input  tbl_en, tbl_we, tbl_addr, tbl_wdata
    );
endinterface

// File: rtl/choice_table_sched.sv
// -----------------------------------------------------------------------------
// choice_table_sched
// Shares one single-port table of 2-bit saturating chooser counters between
// the fetch-stage lookup port and the execute-stage update port.
//   - After reset, walks the whole table writing INIT_VAL, then raises
//     init_done.
//   - Lookups are single-cycle reads; the choice is bit 1 of the counter
//     returned one cycle after acceptance.
//   - Updates are queued in a DEPTH-entry FIFO and applied by a
//     read / wait / write sequence whenever no lookup claims the port.
// Ports:
//   i_clk  : clock, all state on the rising edge
//   i_rst  : synchronous active-high reset
//   io_bus : choice_table_sched_if.slave (lookup, update, table, init_done)
// -----------------------------------------------------------------------------
module choice_table_sched #(
    parameter int         ADDR_W   = 12,
    parameter int         DEPTH    = 4,
    parameter logic [1:0] INIT_VAL = 2'b00
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    choice_table_sched_if.slave   io_bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_UPD_RD = 2'd2,
        ST_UPD_WR = 2'd3
    } state_t;

    // Saturating chooser-counter step: move toward predictor 2 when only it
    // was right, toward predictor 1 when only it was right, else hold.
    function automatic logic [1:0] ctr_update(
        input logic [1:0] cur,
        input logic       taken1,
        input logic       taken2
    );
        logic [1:0] nxt;
        nxt = cur;
        case ({taken1, taken2})
            2'b01: begin
                if (cur != 2'b11) nxt = cur + 2'b01;
                else              nxt = cur;
            end
            2'b10: begin
                if (cur != 2'b00) nxt = cur - 2'b01;
                else              nxt = cur;
            end
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    // Registers
    state_t             r_state;
    logic [ADDR_W-1:0]  r_init_ptr;
    logic               r_init_done;
    logic [ADDR_W-1:0]  r_fifo_addr [DEPTH];
    logic               r_fifo_t1   [DEPTH];
    logic               r_fifo_t2   [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [ADDR_W-1:0]  r_rmw_addr;
    logic               r_rmw_t1;
    logic               r_rmw_t2;
    logic [1:0]         r_rmw_data;
    logic               r_resp_valid;

    // Wires
    state_t             w_next_state;
    logic               w_fifo_empty;
    logic               w_init_last;
    logic               w_push;
    logic               w_pop;
    logic               w_lookup_fire;
    logic               w_lookup_ready;
    logic               w_upd_ready;
    logic               w_tbl_en;
    logic               w_tbl_we;
    logic [ADDR_W-1:0]  w_tbl_addr;
    logic [1:0]         w_tbl_wdata;

    assign w_fifo_empty  = (r_count == {CNT_W{1'b0}});
    assign w_init_last   = (r_state == ST_INIT) && (&r_init_ptr);
    assign w_push        = io_bus.upd_valid && w_upd_ready;
    // The head is popped only when the port is free of lookups; the registered
    // count keeps a same-cycle push from being popped before it is stored.
    assign w_pop         = (r_state == ST_IDLE) && !io_bus.lookup_valid && !w_fifo_empty;
    assign w_lookup_fire = io_bus.lookup_valid && w_lookup_ready;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_INIT;
        else       r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_INIT: begin
                if (w_init_last) w_next_state = ST_IDLE;
                else             w_next_state = ST_INIT;
            end
            ST_IDLE: begin
                if (io_bus.lookup_valid) w_next_state = ST_IDLE;
                else if (!w_fifo_empty)  w_next_state = ST_UPD_RD;
                else                     w_next_state = ST_IDLE;
            end
            ST_UPD_RD: w_next_state = ST_UPD_WR;
            ST_UPD_WR: w_next_state = ST_IDLE;
            default:   w_next_state = ST_INIT;
        endcase
    end

    // Output logic: table strobe and ready flags; everything is held quiet
    // while reset is asserted so an aborted RMW never reaches the table.
    always_comb begin
        w_tbl_en       = 1'b0;
        w_tbl_we       = 1'b0;
        w_tbl_addr     = {ADDR_W{1'b0}};
        w_tbl_wdata    = 2'b00;
        w_lookup_ready = 1'b0;
        w_upd_ready    = 1'b0;
        if (i_rst) begin
            w_tbl_en       = 1'b0;
            w_lookup_ready = 1'b0;
            w_upd_ready    = 1'b0;
        end else begin
            w_upd_ready = (r_state != ST_INIT) && (r_count < CNT_W'(DEPTH));
            case (r_state)
                ST_INIT: begin
                    w_tbl_en    = 1'b1;
                    w_tbl_we    = 1'b1;
                    w_tbl_addr  = r_init_ptr;
                    w_tbl_wdata = INIT_VAL;
                end
                ST_IDLE: begin
                    w_lookup_ready = 1'b1;
                    if (io_bus.lookup_valid) begin
                        w_tbl_en   = 1'b1;
                        w_tbl_we   = 1'b0;
                        w_tbl_addr = io_bus.lookup_addr;
                    end else if (!w_fifo_empty) begin
                        w_tbl_en   = 1'b1;
                        w_tbl_we   = 1'b0;
                        w_tbl_addr = r_fifo_addr[r_rd_ptr];
                    end else begin
                        w_tbl_en   = 1'b0;
                    end
                end
                ST_UPD_RD: begin
                    w_tbl_en = 1'b0;
                end
                ST_UPD_WR: begin
                    // Always written, even when the counter does not move.
                    w_tbl_en    = 1'b1;
                    w_tbl_we    = 1'b1;
                    w_tbl_addr  = r_rmw_addr;
                    w_tbl_wdata = ctr_update(r_rmw_data, r_rmw_t1, r_rmw_t2);
                end
                default: begin
                    w_tbl_en = 1'b0;
                end
            endcase
        end
    end

    // Init walk pointer and sticky init_done flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_init_ptr  <= {ADDR_W{1'b0}};
            r_init_done <= 1'b0;
        end else if (r_state == ST_INIT) begin
            r_init_ptr <= r_init_ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
            if (w_init_last) r_init_done <= 1'b1;
        end
    end

    // FIFO payload storage; contents are irrelevant while the count is zero
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= io_bus.upd_addr;
            r_fifo_t1[r_wr_ptr]   <= io_bus.upd_taken1;
            r_fifo_t2[r_wr_ptr]   <= io_bus.upd_taken2;
        end
    end

    // FIFO pointers and occupancy; reset flushes any queued updates
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
            if (w_pop)  r_rd_ptr <= r_rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

    // RMW holding registers: head captured on pop, old counter in UPD_RD
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rmw_addr <= {ADDR_W{1'b0}};
            r_rmw_t1   <= 1'b0;
            r_rmw_t2   <= 1'b0;
            r_rmw_data <= 2'b00;
        end else begin
            if (w_pop) begin
                r_rmw_addr <= r_fifo_addr[r_rd_ptr];
                r_rmw_t1   <= r_fifo_t1[r_rd_ptr];
                r_rmw_t2   <= r_fifo_t2[r_rd_ptr];
            end
            if (r_state == ST_UPD_RD) r_rmw_data <= io_bus.tbl_rdata;
        end
    end

    // Lookup response strobe, one cycle after acceptance
    always_ff @(posedge i_clk) begin
        if (i_rst) r_resp_valid <= 1'b0;
        else       r_resp_valid <= w_lookup_fire;
    end

    assign io_bus.tbl_en            = w_tbl_en;
    assign io_bus.tbl_we            = w_tbl_we;
    assign io_bus.tbl_addr          = w_tbl_addr;
    assign io_bus.tbl_wdata         = w_tbl_wdata;
    assign io_bus.lookup_ready      = w_lookup_ready;
    assign io_bus.upd_ready         = w_upd_ready;
    assign io_bus.init_done         = r_init_done && !i_rst;
    assign io_bus.lookup_resp_valid = r_resp_valid && !i_rst;
    // Read data arrives in the response cycle; bit 1 means counter >= 2.
    assign io_bus.lookup_choice     = io_bus.tbl_rdata[1];

endmodule

// File: tb/tb_choice_table_sched.sv
// -----------------------------------------------------------------------------
// tb_choice_table_sched
// Bench for choice_table_sched: a RAM model answers table accesses, and a
// reference model (array of counters plus an ordered queue of expected
// writes) predicts every write and every lookup choice.
// -----------------------------------------------------------------------------
module tb_choice_table_sched;

    localparam int         ADDR_W   = 12;
    localparam int         DEPTH    = 4;
    localparam logic [1:0] INIT_VAL = 2'b00;
    localparam int         N        = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        val;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    choice_table_sched_if #(.ADDR_W(ADDR_W)) bus ();

    choice_table_sched #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .INIT_VAL (INIT_VAL)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    // Table RAM: read data valid the cycle after a read strobe
    logic [1:0] mem [N];
    always @(posedge clk) begin
        if (bus.tbl_en) begin
            if (bus.tbl_we) mem[bus.tbl_addr] <= bus.tbl_wdata;
            else            bus.tbl_rdata     <= mem[bus.tbl_addr];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    logic [1:0] model_tbl [N];
    wr_t        exp_q[$];
    int         wr_cyc_q[$];
    int         cyc       = 0;
    int         wr_count  = 0;
    int         init_ptr  = 0;
    bit         seen_done = 1'b0;
    bit         resp_pending = 1'b0;
    bit         resp_known   = 1'b0;
    logic       resp_exp     = 1'b0;

    function automatic logic [1:0] ref_step(input logic [1:0] v, input logic t1, input logic t2);
        int x;
        x = int'(v);
        if (!t1 && t2 && x < 3)      x = x + 1;
        else if (t1 && !t2 && x > 0) x = x - 1;
        return 2'(x);
    endfunction

    function automatic bit addr_pending(input logic [ADDR_W-1:0] a);
        foreach (exp_q[i]) if (exp_q[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    // Monitor: samples at the falling edge, away from the active edge
    always @(negedge clk) begin
        wr_t e;
        logic [1:0] v;
        cyc++;
        if (rst) begin
            check_val("rst_tbl_en", bus.tbl_en, 0);
            check_val("rst_lookup_ready", bus.lookup_ready, 0);
            check_val("rst_upd_ready", bus.upd_ready, 0);
            check_val("rst_resp_valid", bus.lookup_resp_valid, 0);
            check_val("rst_init_done", bus.init_done, 0);
            exp_q.delete();
            for (int i = 0; i < N; i++) model_tbl[i] = INIT_VAL;
            init_ptr     = 0;
            seen_done    = 1'b0;
            resp_pending = 1'b0;
        end else begin
            check_val("resp_valid", bus.lookup_resp_valid, resp_pending);
            if (resp_pending && resp_known) check_val("lookup_choice", bus.lookup_choice, resp_exp);
            resp_pending = 1'b0;
            if (!seen_done && bus.init_done) begin
                check_val("init_len", init_ptr, N);
                seen_done = 1'b1;
            end
            if (!seen_done) begin
                check_val("init_en_we", {bus.tbl_en, bus.tbl_we}, 2'b11);
                check_val("init_addr", 32'(bus.tbl_addr), init_ptr);
                check_val("init_wdata", bus.tbl_wdata, INIT_VAL);
                check_val("init_lookup_ready", bus.lookup_ready, 0);
                check_val("init_upd_ready", bus.upd_ready, 0);
                init_ptr++;
            end else begin
                check_val("init_done_hold", bus.init_done, 1);
                if (bus.tbl_en && bus.tbl_we) begin
                    wr_count++;
                    wr_cyc_q.push_back(cyc);
                    check_val("wr_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check_val("wr_addr", bus.tbl_addr, e.addr);
                        check_val("wr_data", bus.tbl_wdata, e.val);
                    end
                end
                if (bus.lookup_valid && bus.lookup_ready) begin
                    check_val("lk_rd_strobe", {bus.tbl_en, bus.tbl_we}, 2'b10);
                    check_val("lk_rd_addr", bus.tbl_addr, bus.lookup_addr);
                    resp_pending = 1'b1;
                    resp_known   = !addr_pending(bus.lookup_addr);
                    resp_exp     = model_tbl[bus.lookup_addr][1];
                end
                if (bus.upd_valid && bus.upd_ready) begin
                    v = ref_step(model_tbl[bus.upd_addr], bus.upd_taken1, bus.upd_taken2);
                    model_tbl[bus.upd_addr] = v;
                    e.addr = bus.upd_addr;
                    e.val  = v;
                    exp_q.push_back(e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init();
        int n = 0;
        while (!bus.init_done && n < 6000) begin tick(); n++; end
        check_val("init_timeout", bus.init_done, 1);
    endtask

    task automatic push_upd(input logic [ADDR_W-1:0] a, input logic t1, input logic t2);
        int n = 0;
        bit ok = 1'b0;
        bus.upd_valid  = 1'b1;
        bus.upd_addr   = a;
        bus.upd_taken1 = t1;
        bus.upd_taken2 = t2;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = bus.upd_ready;
            tick();
            n++;
        end
        bus.upd_valid = 1'b0;
        check_val("push_timeout", ok, 1);
    endtask

    task automatic do_lookup(input logic [ADDR_W-1:0] a);
        int n = 0;
        bit ok = 1'b0;
        bus.lookup_valid = 1'b1;
        bus.lookup_addr  = a;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = bus.lookup_ready;
            tick();
            n++;
        end
        bus.lookup_valid = 1'b0;
        check_val("lookup_timeout", ok, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || resp_pending) && n < 500) begin tick(); n++; end
        tick();
        check_val("drain", exp_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, n, wr0, wait_cyc, sz;
        bit ok;
        bus.lookup_valid = 1'b0;
        bus.lookup_addr  = '0;
        bus.upd_valid    = 1'b0;
        bus.upd_addr     = '0;
        bus.upd_taken1   = 1'b0;
        bus.upd_taken2   = 1'b0;

        // Reset and full init walk
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        wait_init();

        // Counter up to saturation, then lookup
        repeat (3) push_upd(12'h010, 1'b0, 1'b1);
        drain();
        do_lookup(12'h010);
        drain();

        // Counter down past zero, lookup, then neutral updates
        repeat (4) push_upd(12'h010, 1'b1, 1'b0);
        drain();
        do_lookup(12'h010);
        push_upd(12'h010, 1'b1, 1'b1);
        push_upd(12'h010, 1'b0, 1'b0);
        push_upd(12'h011, 1'b0, 1'b1);
        push_upd(12'h011, 1'b0, 1'b1);
        push_upd(12'h011, 1'b1, 1'b1);
        drain();
        do_lookup(12'h011);
        drain();

        // Lookups hold the port while updates fill the FIFO
        sent = 0;
        wr0  = wr_count;
        bus.lookup_valid = 1'b1;
        bus.upd_valid    = 1'b1;
        bus.upd_addr     = 12'h100;
        bus.upd_taken1   = 1'b0;
        bus.upd_taken2   = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bus.lookup_addr = ADDR_W'($urandom);
            @(negedge clk);
            if (bus.upd_ready) sent++;
            tick();
            bus.upd_addr = ADDR_W'(12'h100 + sent);
        end
        check_val("bp_accepted", sent, DEPTH);
        check_val("bp_no_writes", wr_count - wr0, 0);
        bus.lookup_valid = 1'b0;
        n = 0;
        while (sent < 5 && n < 50) begin
            @(negedge clk);
            if (bus.upd_ready) sent++;
            tick();
            n++;
        end
        bus.upd_valid = 1'b0;
        check_val("bp_fifth", sent, 5);
        drain();
        sz = wr_cyc_q.size();
        check_val("bp_wr_seen", wr_count - wr0, 5);
        if (sz >= 5) begin
            for (int i = sz - 4; i < sz; i++)
                check_val("bp_spacing", wr_cyc_q[i] - wr_cyc_q[i-1], 3);
        end

        // Lookup arriving while an RMW is in UPD_RD
        bus.upd_valid  = 1'b1;
        bus.upd_addr   = 12'h020;
        bus.upd_taken1 = 1'b0;
        bus.upd_taken2 = 1'b1;
        tick();
        bus.upd_valid = 1'b0;
        tick();
        bus.lookup_valid = 1'b1;
        bus.lookup_addr  = 12'h020;
        wait_cyc = 0;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 10) begin
            @(negedge clk);
            ok = bus.lookup_ready;
            if (!ok) wait_cyc++;
            tick();
            n++;
        end
        bus.lookup_valid = 1'b0;
        check_val("rd_stall_cycles", wait_cyc, 2);
        drain();

        // Reset during UPD_WR with a second update still queued
        bus.upd_valid  = 1'b1;
        bus.upd_addr   = 12'h030;
        bus.upd_taken1 = 1'b0;
        bus.upd_taken2 = 1'b1;
        tick();
        bus.upd_addr = 12'h031;
        tick();
        bus.upd_valid = 1'b0;
        tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;

        // Reset again when the init walk reaches 0x200
        ok = 1'b0;
        n = 0;
        while (!ok && n < 1000) begin
            @(negedge clk);
            ok = !bus.init_done && (bus.tbl_addr == 12'h1FF);
            n++;
        end
        check_val("init_reach_1ff", ok, 1);
        tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        wait_init();

        // Flushed FIFO: no writes appear after init
        wr0 = wr_count;
        repeat (30) tick();
        check_val("flush_no_writes", wr_count - wr0, 0);
        do_lookup(12'h030);
        do_lookup(12'h010);
        drain();

        // Randomized traffic on a small address window
        for (int c = 0; c < 400; c++) begin
            bus.lookup_valid = ($urandom_range(0, 2) == 0);
            bus.lookup_addr  = ADDR_W'($urandom_range(0, 7));
            bus.upd_valid    = $urandom_range(0, 1);
            bus.upd_addr     = ADDR_W'($urandom_range(0, 7));
            bus.upd_taken1   = $urandom_range(0, 1);
            bus.upd_taken2   = $urandom_range(0, 1);
            tick();
        end
        bus.lookup_valid = 1'b0;
        bus.upd_valid    = 1'b0;
        drain();
        for (int a = 0; a < 8; a++) do_lookup(ADDR_W'(a));
        drain();

        check_val("end_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
